// File: rtl/pueo_trig_pkg.sv
// Shared trigger-path definitions: beam count, threshold word type and the
// threshold loader state encoding.
package pueo_trig_pkg;

  localparam int NBEAMS      = 46;
  localparam int THRESH_BITS = 18;
  localparam int IDX_BITS    = $clog2(NBEAMS);

  typedef logic [THRESH_BITS-1:0] thresh_t;
  typedef logic [IDX_BITS-1:0]    beam_idx_t;
  typedef logic [NBEAMS-1:0]      beam_mask_t;

  localparam thresh_t   THRESH_DEFAULT = 18'h3FFFF;
  localparam beam_idx_t LAST_BEAM      = beam_idx_t'(NBEAMS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2
  } thr_load_state_t;

  function automatic beam_mask_t beam_onehot(input beam_idx_t k);
    beam_mask_t m;
    m    = '0;
    m[k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/beam_threshold_loader.sv
// Shadow threshold table with a valid/ready write port; a commit walks the
// table out to the beamformers one beam per cycle, then pulses update.
//
//  state  | meaning
//  IDLE   | table writable, waiting for commit
//  LOAD   | one ce strobe per cycle, beam idx_q
//  UPDATE | ce quiet, update/done pulse
module beam_threshold_loader
  import pueo_trig_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [IDX_BITS-1:0]    wr_beam_i,
  input  logic [THRESH_BITS-1:0] wr_thresh_i,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_idx_o,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o
);

  thr_load_state_t state_q, state_d;
  beam_idx_t       idx_q, idx_d;
  thresh_t         shadow_q [NBEAMS];
  thresh_t         shadow_d [NBEAMS];
  thresh_t         thresh_q, thresh_d;
  beam_mask_t      ce_q, ce_d;
  logic            update_q, update_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            wr_acc;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    thresh_d = thresh_q;
    err_d    = err_q;
    ce_d     = '0;
    update_d = 1'b0;

    // ready_q is only ever high while IDLE, so this also gates writes to IDLE
    wr_acc = wr_valid_i & ready_q;
    if (wr_acc) begin
      if (wr_beam_i <= LAST_BEAM) begin
        shadow_d[wr_beam_i] = wr_thresh_i;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (commit_i) begin
          state_d  = LOAD;
          idx_d    = '0;
          ce_d     = beam_onehot('0);
          // a write landing on the commit edge must reach the first strobe
          thresh_d = shadow_d[0];
        end
      end
      LOAD: begin
        if (idx_q == LAST_BEAM) begin
          state_d  = UPDATE;
          update_d = 1'b1;
        end else begin
          idx_d    = idx_q + beam_idx_t'(1);
          ce_d     = beam_onehot(idx_d);
          thresh_d = shadow_q[idx_d];
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      thresh_q <= '0;
      ce_q     <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NBEAMS; i++) begin
        shadow_q[i] <= THRESH_DEFAULT;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      thresh_q <= thresh_d;
      ce_q     <= ce_d;
      update_q <= update_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      for (int i = 0; i < NBEAMS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign wr_ready_o  = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = update_q;
  assign update_o    = update_q;
  assign err_idx_o   = err_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Directed bench for beam_threshold_loader: a cycle-offset model of the load
// sequence checked every cycle, plus literal expectations per scenario.
module tb_beam_threshold_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_beam = '0;
  logic [17:0] wr_thr = '0;
  logic        commit = 1'b0;
  logic        busy, done, err_idx, update;
  logic [17:0] thresh;
  logic [45:0] ce;

  beam_threshold_loader dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_beam_i(wr_beam), .wr_thresh_i(wr_thr),
    .commit_i(commit), .busy_o(busy), .done_o(done), .err_idx_o(err_idx),
    .thresh_o(thresh), .thresh_ce_o(ce), .update_o(update)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int commit_cyc = 0;

  // model: t = cycles into the load sequence (1..46 strobes, 47 update), -1 idle
  int t = -1;
  int m_shadow [46];
  int m_snap [46];
  bit m_err = 0;
  bit m_rdy = 0;

  // monitor captures
  int cap_thr [46];
  int cap_off [46];
  int strobes = 0;
  int upd_cnt = 0;
  int upd_off = 0;
  int busy_low_off = 0;
  bit prev_busy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = -1; m_err = 0; m_rdy = 0;
      for (int i = 0; i < 46; i++) m_shadow[i] = 'h3FFFF;
    end else begin
      bit idle;
      idle = (t < 0);
      if (wr_valid && m_rdy) begin
        if (wr_beam < 46) m_shadow[wr_beam] = wr_thr;
        else m_err = 1;
      end
      if (!idle) begin
        t++;
        if (t > 47) t = -1;
      end else if (commit) begin
        m_snap = m_shadow;
        t = 1;
      end
      m_rdy = (t < 0);
    end
  end

  initial forever begin
    logic [45:0] exp_ce;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ce", ce, 0);
      chk("rst_busy", busy, 0);
      chk("rst_update", update, 0);
      chk("rst_ready", wr_ready, 0);
      chk("rst_err", err_idx, 0);
    end else begin
      exp_ce = (t >= 1 && t <= 46) ? (46'b1 << (t - 1)) : '0;
      chk("ce", ce, exp_ce);
      chk("ce_onehot0", $onehot0(ce), 1);
      chk("busy", busy, (t >= 1 && t <= 47));
      chk("update", update, (t == 47));
      chk("done", done, (t == 47));
      chk("ready", wr_ready, m_rdy);
      chk("err_idx", err_idx, m_err);
      if (exp_ce != 0) chk("thresh", thresh, m_snap[t-1]);
      if (ce != 0) begin
        for (int k = 0; k < 46; k++) begin
          if (ce[k]) begin
            cap_thr[k] = thresh;
            cap_off[k] = cyc - commit_cyc + 1;
          end
        end
        strobes++;
      end
      if (update) begin
        upd_cnt++;
        upd_off = cyc - commit_cyc + 1;
      end
      if (prev_busy && !busy) busy_low_off = cyc - commit_cyc + 1;
    end
    prev_busy = busy;
  end

  task automatic clear_caps();
    for (int k = 0; k < 46; k++) begin
      cap_thr[k] = -1;
      cap_off[k] = -1;
    end
    strobes = 0; upd_cnt = 0; upd_off = 0; busy_low_off = 0;
  endtask

  task automatic do_write(input int b, input int v);
    int n = 0;
    @(negedge clk);
    wr_valid = 1; wr_beam = 6'(b); wr_thr = 18'(v);
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_handshake_timeout", (n < 100), 1);
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic do_commit(input bit with_wr, input int b, input int v);
    @(negedge clk);
    clear_caps();
    commit = 1;
    if (with_wr) begin
      wr_valid = 1; wr_beam = 6'(b); wr_thr = 18'(v);
    end
    commit_cyc = cyc + 1;
    @(negedge clk);
    commit = 0; wr_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 200), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic count_bad_defaults(input string nm, input int skip);
    int bad = 0;
    for (int k = 0; k < 46; k++)
      if (k != skip && cap_thr[k] != 'h3FFFF) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    clear_caps();
    repeat (3) @(negedge clk);
    rst_n = 1;

    // 1: defaults only
    do_commit(0, 0, 0);
    wait_idle();
    chk("t1_strobes", strobes, 46);
    count_bad_defaults("t1_defaults", -1);
    chk("t1_bit0_off", cap_off[0], 1);
    chk("t1_bit45_off", cap_off[45], 46);
    chk("t1_upd_cnt", upd_cnt, 1);
    chk("t1_upd_off", upd_off, 47);
    chk("t1_busy_low_off", busy_low_off, 48);

    // 2: two written beams
    do_write(5, 1234);
    do_write(45, 77);
    do_commit(0, 0, 0);
    wait_idle();
    chk("t2_b5_thr", cap_thr[5], 1234);
    chk("t2_b5_off", cap_off[5], 6);
    chk("t2_b45_thr", cap_thr[45], 77);
    chk("t2_b45_off", cap_off[45], 46);
    chk("t2_b0_thr", cap_thr[0], 'h3FFFF);
    chk("t2_b44_thr", cap_thr[44], 'h3FFFF);

    // 3: out-of-range index
    do_reset();
    do_write(46, 555);
    chk("t3_err_set", err_idx, 1);
    do_commit(0, 0, 0);
    wait_idle();
    count_bad_defaults("t3_defaults", -1);
    chk("t3_err_sticky", err_idx, 1);

    // 4: write coincident with commit reaches first strobe
    do_commit(1, 0, 9);
    wait_idle();
    chk("t4_b0_thr", cap_thr[0], 9);
    count_bad_defaults("t4_others", 0);

    // 5: commit and write while loading
    do_commit(0, 0, 0);
    repeat (10) @(negedge clk);
    commit = 1; wr_valid = 1; wr_beam = 6'd3; wr_thr = 18'd42;
    @(negedge clk);
    commit = 0;
    chk("t5_ready_low", wr_ready, 0);
    begin
      int n = 0;
      while (!wr_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5_ready_timeout", (n < 100), 1);
    end
    @(negedge clk);
    wr_valid = 0;
    wait_idle();
    chk("t5_single_update", upd_cnt, 1);
    chk("t5_b3_old", cap_thr[3], 'h3FFFF);
    do_commit(0, 0, 0);
    wait_idle();
    chk("t5_b3_new", cap_thr[3], 42);
    chk("t5_b0_kept", cap_thr[0], 9);

    // 6: reset mid-load
    do_commit(0, 0, 0);
    repeat (19) @(posedge clk);
    #1;
    chk("t6_pre_ce", ce, 46'b1 << 19);
    upd_cnt = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_ce_drop", ce, 0);
    chk("t6_busy_drop", busy, 0);
    chk("t6_update_low", update, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (60) @(negedge clk);
    chk("t6_no_update", upd_cnt, 0);
    do_commit(0, 0, 0);
    wait_idle();
    chk("t6_b0_default", cap_thr[0], 'h3FFFF);
    chk("t6_b3_default", cap_thr[3], 'h3FFFF);
    chk("t6_err_cleared", err_idx, 0);
    chk("t6_strobes", strobes, 46);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
